// File: rtl/mem_bus_arbiter_if.sv
// Request/response bundle between the fetch port, the data port and the bus bridge.
// The slave modport is the arbiter's view; master is the view of the surrounding pipeline and bridge.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    logic              bus_req;
    logic              bus_wr;
    logic [1:0]        bus_size;
    logic [3:0]        bus_wstrb;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding arbiter sharing one sram-like bus between fetch and data ports.
// Optional ARB_STARVE_GUARD_EN forces a waiting fetch after STARVE_MAX back-to-back data grants.
//
// state  | meaning
// IDLE   | no transaction; arbitration happens here
// I_ADDR | fetch request presented to the bridge
// D_ADDR | data request presented to the bridge
// I_WAIT | fetch accepted, waiting for response
// D_WAIT | data accepted, waiting for response
module mem_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    mem_bus_arbiter_if.slave      bus,
    output logic                  busy
);

    typedef enum logic [2:0] {IDLE, I_ADDR, D_ADDR, I_WAIT, D_WAIT} state_t;

    state_t            state, state_nxt;
    logic              drop, drop_nxt;
    logic              inst_forced;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            drop  <= 1'b0;
        end else begin
            state <= state_nxt;
            drop  <= drop_nxt;
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] starve_cnt, starve_nxt;

    assign inst_forced = bus.inst_req && (starve_cnt == CNT_W'(STARVE_MAX));

    // Only counts while a fetch is actually waiting; any other arbitration outcome clears it.
    always_comb begin
        starve_nxt = starve_cnt;
        if (state == IDLE) begin
            if (bus.data_req && !inst_forced && bus.inst_req)
                starve_nxt = starve_cnt + 1'b1;
            else
                starve_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) starve_cnt <= '0;
        else         starve_cnt <= starve_nxt;
    end
`else
    // Parameter stays in the port list so both builds instantiate identically.
    logic [31:0] starve_unused;
    assign starve_unused = 32'(STARVE_MAX);
    assign inst_forced   = 1'b0;
`endif

    always_comb begin
        state_nxt        = state;
        drop_nxt         = drop;
        bus.bus_req      = 1'b0;
        bus.bus_wr       = 1'b0;
        bus.bus_size     = 2'd0;
        bus.bus_wstrb    = 4'd0;
        sel_addr         = '0;
        sel_wdata        = '0;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        case (state)
            IDLE: begin
                if (inst_forced)       state_nxt = I_ADDR;
                else if (bus.data_req) state_nxt = D_ADDR;
                else if (bus.inst_req) state_nxt = I_ADDR;
            end
            I_ADDR: begin
                if (bus.inst_req) begin
                    bus.bus_req      = 1'b1;
                    bus.bus_size     = 2'd2;
                    sel_addr         = bus.inst_addr;
                    bus.inst_addr_ok = bus.bus_addr_ok;
                    if (bus.bus_addr_ok) begin
                        state_nxt = I_WAIT;
                        drop_nxt  = flush;
                    end else if (flush) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            D_ADDR: begin
                if (bus.data_req) begin
                    bus.bus_req      = 1'b1;
                    bus.bus_wr       = bus.data_wr;
                    bus.bus_size     = bus.data_size;
                    bus.bus_wstrb    = bus.data_wstrb;
                    sel_addr         = bus.data_addr;
                    sel_wdata        = bus.data_wdata;
                    bus.data_addr_ok = bus.bus_addr_ok;
                    if (bus.bus_addr_ok) state_nxt = D_WAIT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            I_WAIT: begin
                if (flush) drop_nxt = 1'b1;
                // A flush landing on the response cycle also kills the response.
                if (bus.bus_data_ok) begin
                    bus.inst_data_ok = !drop && !flush;
                    drop_nxt         = 1'b0;
                    state_nxt        = IDLE;
                end
            end
            D_WAIT: begin
                if (bus.bus_data_ok) begin
                    bus.data_data_ok = 1'b1;
                    state_nxt        = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.bus_addr   = sel_addr;
    assign bus.bus_wdata  = sel_wdata;
    assign bus.inst_rdata = bus.bus_rdata;
    assign bus.data_rdata = bus.bus_rdata;
    assign busy           = (state != IDLE);

endmodule
